// File: rtl/mem_io_resp_pkg.sv
// Shared constants for the mem_io_resp CPU memory/IO responder: IO decode
// addresses and the read-data source selector.
package mem_io_resp_pkg;

    localparam logic [17:0] IO_BASE = 18'h30000;  // UART data port
    localparam logic [17:0] IO_CLK  = 18'h30004;  // cycle counter snapshot / stop port
    localparam logic [1:0]  IO_SEL  = 2'b11;      // mem_a[17:16] value selecting IO space

    typedef enum logic {
        SRC_RAM = 1'b0,
        SRC_IO  = 1'b1
    } rd_src_e;

endpackage

// File: rtl/mem_io_resp_io_byte_fifo.sv
// io_byte_fifo: byte FIFO with extra-MSB pointers; a pop in the same cycle
// frees a slot for a push into a full FIFO. Head reads 0x00 when empty.
module io_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty,
    output logic       push_drop
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = $clog2(DEPTH) + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_idx, rd_idx;
    logic [7:0]    slot_q [DEPTH];
    logic          do_push, do_pop;

    generate
        if (DEPTH == 1) begin : g_single
            assign wr_idx = '0;
            assign rd_idx = '0;
            assign full   = (wr_ptr_q[0] != rd_ptr_q[0]);
        end else begin : g_multi
            assign wr_idx = wr_ptr_q[AW-1:0];
            assign rd_idx = rd_ptr_q[AW-1:0];
            assign full   = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                            (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        end
    endgenerate

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign push_drop = push && !do_push;
    assign head      = empty ? 8'h00 : slot_q[rd_idx];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is deliberately unreset; emptiness is tracked by the pointers alone.
    always_ff @(posedge clk_in) begin
        if (do_push) slot_q[wr_idx] <= push_data;
    end

endmodule

// File: rtl/mem_io_resp.sv
// mem_io_resp: zero-wait byte RAM plus UART RX/TX FIFOs and a cycle counter,
// all with one-cycle read latency. Define MEM_IO_RESP_TX_FIFO_EN for a full TX FIFO.
module mem_io_resp
    import mem_io_resp_pkg::*;
#(
    parameter int RAM_ADDR_W = 17,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        prog_stop,
    output logic        tx_ovf
);

`ifdef MEM_IO_RESP_TX_FIFO_EN
    localparam int TX_DEPTH = FIFO_DEPTH;
`else
    localparam int TX_DEPTH = 1;
`endif
    localparam int RAM_WORDS = 1 << RAM_ADDR_W;

    logic [7:0]            ram_q [RAM_WORDS];
    logic [7:0]            ram_rd_q;
    logic [RAM_ADDR_W-1:0] ram_idx;
    logic [17:0]           io_addr;
    logic                  is_io;
    rd_src_e               src_q, src_d;
    logic [7:0]            io_rd_q, io_rd_d;
    logic [31:0]           cnt_q, cnt_d, snap_q, snap_d;
    logic                  stop_q, stop_d, ovf_q, ovf_d;
    logic                  rx_pop, rx_empty, rx_drop;
    logic [7:0]            rx_head;
    logic                  tx_push, tx_pop, tx_full, tx_empty, tx_drop;
    logic [7:0]            tx_push_data;
    logic                  unused_ok;

    assign io_addr   = mem_a[17:0];
    assign is_io     = (mem_a[17:16] == IO_SEL);
    assign ram_idx   = mem_a[RAM_ADDR_W-1:0];
    assign unused_ok = ^{mem_a[31:18], rx_empty, rx_drop, tx_full};

    always_ff @(posedge clk_in) begin
        if (mem_wr && !is_io) ram_q[ram_idx] <= mem_dout;
        ram_rd_q <= ram_q[ram_idx];
    end

    io_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .push      (rx_valid),
        .push_data (rx_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .push_drop (rx_drop)
    );

    io_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .push      (tx_push),
        .push_data (tx_push_data),
        .pop       (tx_pop),
        .head      (tx_data),
        .full      (tx_full),
        .empty     (tx_empty),
        .push_drop (tx_drop)
    );

    assign tx_valid = !tx_empty;
    assign tx_pop   = tx_valid && tx_ready;
    assign ovf_d    = ovf_q | tx_drop;

    always_comb begin
        cnt_d        = cnt_q + 32'd1;
        snap_d       = snap_q;
        stop_d       = stop_q;
        src_d        = is_io ? SRC_IO : SRC_RAM;
        io_rd_d      = 8'h00;
        rx_pop       = 1'b0;
        tx_push      = 1'b0;
        tx_push_data = 8'h00;
        if (is_io && mem_wr) begin
            if (io_addr == IO_BASE) begin
                tx_push      = (mem_dout != 8'h00);
                tx_push_data = mem_dout;
            end else if (io_addr == IO_CLK) begin
                tx_push = 1'b1;
                stop_d  = 1'b1;
            end
        end else if (is_io) begin
            // Only the low byte read re-latches, so multi-byte reads never tear.
            case (io_addr)
                IO_BASE: begin
                    rx_pop  = 1'b1;
                    io_rd_d = rx_head;
                end
                IO_CLK: begin
                    snap_d  = cnt_q;
                    io_rd_d = cnt_q[7:0];
                end
                IO_CLK + 18'd1: io_rd_d = snap_q[15:8];
                IO_CLK + 18'd2: io_rd_d = snap_q[23:16];
                IO_CLK + 18'd3: io_rd_d = snap_q[31:24];
                default:        io_rd_d = 8'h00;
            endcase
        end
    end

    // Resetting the source to IO with zero data keeps mem_din at 0 until a real read.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            src_q   <= SRC_IO;
            io_rd_q <= 8'h00;
            cnt_q   <= 32'd0;
            snap_q  <= 32'd0;
            stop_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            src_q   <= src_d;
            io_rd_q <= io_rd_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            stop_q  <= stop_d;
            ovf_q   <= ovf_d;
        end
    end

    assign mem_din   = (src_q == SRC_RAM) ? ram_rd_q : io_rd_q;
    assign prog_stop = stop_q;
    assign tx_ovf    = ovf_q;

endmodule

// File: tb/tb_mem_io_resp.sv
// Directed bench for mem_io_resp: expected read bytes queue in a scoreboard
// when the address is driven and are popped one cycle later.
module tb_mem_io_resp;

    localparam int FIFO_DEPTH = 8;
`ifdef MEM_IO_RESP_TX_FIFO_EN
    localparam int TXD = FIFO_DEPTH;
`else
    localparam int TXD = 1;
`endif

    logic        clk_in   = 1'b0;
    logic        rst_n_in = 1'b0;
    logic [31:0] mem_a    = 32'h0;
    logic [7:0]  mem_dout = 8'h0;
    logic        mem_wr   = 1'b0;
    logic [7:0]  mem_din;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data  = 8'h0;
    logic        rx_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        prog_stop;
    logic        tx_ovf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } sb_t;

    sb_t         sb_q [$];
    logic [7:0]  ram_m [int];
    logic [7:0]  rxq [$];
    logic [7:0]  txq [$];
    logic [31:0] cnt_m;
    logic [31:0] snap_m = 32'h0;
    logic        stop_m = 1'b0;
    logic        ovf_m  = 1'b0;

    mem_io_resp #(.RAM_ADDR_W(17), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .mem_a     (mem_a),
        .mem_dout  (mem_dout),
        .mem_wr    (mem_wr),
        .mem_din   (mem_din),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_full   (rx_full),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .prog_stop (prog_stop),
        .tx_ovf    (tx_ovf)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) cnt_m <= 32'd0;
        else           cnt_m <= cnt_m + 32'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, " tx_valid"},  {31'd0, tx_valid},  (txq.size() != 0) ? 32'd1 : 32'd0);
        check({tag, " tx_data"},   {24'd0, tx_data},   (txq.size() != 0) ? {24'd0, txq[0]} : 32'd0);
        check({tag, " rx_full"},   {31'd0, rx_full},   (rxq.size() == FIFO_DEPTH) ? 32'd1 : 32'd0);
        check({tag, " prog_stop"}, {31'd0, prog_stop}, {31'd0, stop_m});
        check({tag, " tx_ovf"},    {31'd0, tx_ovf},    {31'd0, ovf_m});
    endtask

    // One bus cycle: drive, queue the expected read byte, update the model, clock, compare.
    task automatic step(input string tag, input logic [31:0] a, input bit w, input logic [7:0] d,
                        input bit rxv = 1'b0, input logic [7:0] rxd = 8'h0, input bit trdy = 1'b0,
                        input bit use_c = 1'b0, input logic [7:0] c = 8'h0);
        bit          io, have, pop_rx, pop_tx, push_tx;
        logic [7:0]  e;
        logic [17:0] off;
        sb_t         ent;
        mem_a = a; mem_wr = w; mem_dout = d;
        rx_valid = rxv; rx_data = rxd; tx_ready = trdy;
        io     = (a[17:16] == 2'b11);
        off    = a[17:0];
        have   = 1'b0;
        e      = 8'h00;
        pop_rx = !w && io && (off == 18'h30000) && (rxq.size() > 0);
        if (!w && io) begin
            have = 1'b1;
            case (off)
                18'h30000: e = pop_rx ? rxq[0] : 8'h00;
                18'h30004: e = cnt_m[7:0];
                18'h30005: e = snap_m[15:8];
                18'h30006: e = snap_m[23:16];
                18'h30007: e = snap_m[31:24];
                default:   e = 8'h00;
            endcase
        end else if (!w && ram_m.exists(int'(a[16:0]))) begin
            have = 1'b1;
            e    = ram_m[int'(a[16:0])];
        end
        if (use_c) begin
            have = 1'b1;
            e    = c;
        end
        if (have) begin
            ent.tag = tag;
            ent.exp = e;
            sb_q.push_back(ent);
        end
        if (!w && io && off == 18'h30004) snap_m = cnt_m;
        if (w && !io) ram_m[int'(a[16:0])] = d;
        if (pop_rx) void'(rxq.pop_front());
        if (rxv && rxq.size() < FIFO_DEPTH) rxq.push_back(rxd);
        pop_tx  = trdy && (txq.size() > 0);
        push_tx = w && io && ((off == 18'h30000 && d != 8'h00) || off == 18'h30004);
        if (pop_tx) void'(txq.pop_front());
        if (push_tx) begin
            if (txq.size() < TXD) txq.push_back((off == 18'h30004) ? 8'h00 : d);
            else                  ovf_m = 1'b1;
        end
        if (w && io && off == 18'h30004) stop_m = 1'b1;
        @(posedge clk_in);
        #1;
        if (have) begin
            ent = sb_q.pop_front();
            check({ent.tag, " mem_din"}, {24'd0, mem_din}, {24'd0, ent.exp});
        end
        check_status(tag);
    endtask

    task automatic drain_tx(input string tag);
        for (int k = 0; k < 40 && txq.size() > 0; k++)
            step(tag, 32'h10, 1'b0, 8'h0, 1'b0, 8'h0, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        check("rst mem_din", {24'd0, mem_din}, 32'd0);
        check_status("rst");
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;

        // RAM write then read-after-write, plus upper address bits ignored
        step("ram_wr",    32'h0000_0010, 1'b1, 8'hA5);
        step("ram_rd",    32'h0000_0010, 1'b0, 8'h00, 1'b0, 8'h0, 1'b0, 1'b1, 8'hA5);
        step("ram_wr2",   32'h0000_0011, 1'b1, 8'h3C);
        step("ram_rd2",   32'h0000_0011, 1'b0, 8'h00);
        step("ram_rd3",   32'h0000_0010, 1'b0, 8'h00);
        step("ram_alias", 32'hFFF2_0011, 1'b0, 8'h00);

        // RX FIFO
        step("rx_push1", 32'h10, 1'b0, 8'h0, 1'b1, 8'h41);
        step("rx_push2", 32'h10, 1'b0, 8'h0, 1'b1, 8'h42);
        step("rx_rd1", 32'h30000, 1'b0, 8'h0, 1'b0, 8'h0, 1'b0, 1'b1, 8'h41);
        step("rx_rd2", 32'h30000, 1'b0, 8'h0, 1'b0, 8'h0, 1'b0, 1'b1, 8'h42);
        step("rx_rd3", 32'h30000, 1'b0, 8'h0, 1'b0, 8'h0, 1'b0, 1'b1, 8'h00);
        step("rx_same", 32'h30000, 1'b0, 8'h0, 1'b1, 8'h55);
        step("rx_rd4", 32'h30000, 1'b0, 8'h0);
        for (int i = 0; i < FIFO_DEPTH; i++)
            step("rx_fill", 32'h10, 1'b0, 8'h0, 1'b1, 8'h60 + 8'(i));
        step("rx_drop", 32'h10, 1'b0, 8'h0, 1'b1, 8'h99);
        step("rx_full_pp", 32'h30000, 1'b0, 8'h0, 1'b1, 8'h9A);
        for (int i = 0; i < FIFO_DEPTH; i++)
            step("rx_drain", 32'h30000, 1'b0, 8'h0);

        // Unused IO addresses and zero data writes
        step("io_other_rd", 32'h30008, 1'b0, 8'h00);
        step("io_other_wr", 32'h30008, 1'b1, 8'h12);
        step("io_wr_zero",  32'h30000, 1'b1, 8'h00);

        // Counter snapshot at a known count
        while (cnt_m < 32'h123) step("idle", 32'h10, 1'b0, 8'h0);
        step("clk_b0", 32'h30004, 1'b0, 8'h0, 1'b0, 8'h0, 1'b0, 1'b1, 8'h23);
        step("clk_b1", 32'h30005, 1'b0, 8'h0, 1'b0, 8'h0, 1'b0, 1'b1, 8'h01);
        step("clk_b2", 32'h30006, 1'b0, 8'h0, 1'b0, 8'h0, 1'b0, 1'b1, 8'h00);
        step("clk_b3", 32'h30007, 1'b0, 8'h0, 1'b0, 8'h0, 1'b0, 1'b1, 8'h00);
        repeat (3) step("idle", 32'h10, 1'b0, 8'h0);
        step("clk_b1_again", 32'h30005, 1'b0, 8'h0, 1'b0, 8'h0, 1'b0, 1'b1, 8'h01);

        // TX: a pop in the same cycle frees room for a push into a full TX
        for (int i = 0; i < TXD; i++)
            step("tx_fill", 32'h30000, 1'b1, 8'h10 + 8'(i));
        step("tx_push_pop", 32'h30000, 1'b1, 8'h77, 1'b0, 8'h0, 1'b1);
        drain_tx("tx_drain");

        // TX overflow with tx_ready low, then a zero write changes nothing
        for (int i = 0; i < 9; i++)
            step("tx_ovf_fill", 32'h30000, 1'b1, 8'hB0 + 8'(i));
        step("tx_zero", 32'h30000, 1'b1, 8'h00);
        drain_tx("tx_ovf_drain");

        // Stop write
        step("stop", 32'h30004, 1'b1, 8'hEE);
        step("stop_hold", 32'h10, 1'b0, 8'h0);
        drain_tx("stop_drain");

        // Load state, then assert reset in the middle of a read
        for (int i = 0; i < FIFO_DEPTH; i++)
            step("pre_rst_rx", 32'h10, 1'b0, 8'h0, 1'b1, 8'hC0 + 8'(i));
        step("pre_rst_tx", 32'h30000, 1'b1, 8'h5A);
        mem_a = 32'h10; mem_wr = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
        @(posedge clk_in);
        #1;
        check("pre_rst mem_din", {24'd0, mem_din}, 32'hA5);
        mem_a = 32'h30004;
        #3;
        rst_n_in = 1'b0;
        #1;
        rxq.delete(); txq.delete();
        snap_m = 32'h0; stop_m = 1'b0; ovf_m = 1'b0;
        check("mid_rst mem_din", {24'd0, mem_din}, 32'd0);
        check_status("mid_rst");
        mem_a = 32'h10;
        @(posedge clk_in);
        #1;
        check("in_rst mem_din", {24'd0, mem_din}, 32'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;

        // After reset: RAM retained, snapshot cleared, counter restarted, RX empty
        step("post_ram",  32'h10,    1'b0, 8'h0, 1'b0, 8'h0, 1'b0, 1'b1, 8'hA5);
        step("post_snap", 32'h30005, 1'b0, 8'h0);
        step("post_clk",  32'h30004, 1'b0, 8'h0);
        step("post_rx",   32'h30000, 1'b0, 8'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_io_resp.md
MEM_IO_RESP -- requirements
Module: mem_io_resp

Interface
REQ-001 Parameter RAM_ADDR_W, default 17, RAM byte-address width (128 KB).
REQ-002 Parameter FIFO_DEPTH, default 8, depth of the RX and TX byte FIFOs; power of two, at least 2.
REQ-003 clk_in  input  1  system clock; all state on rising edge.
REQ-004 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-005 mem_a  input  32  CPU address bus; only bits [17:0] decoded.
REQ-006 mem_dout  input  8  CPU write data.
REQ-007 mem_wr  input  1  1 = write, 0 = read.
REQ-008 mem_din  output  8  read data returned to the CPU.
REQ-009 rx_valid / rx_data  input  1 / 8  incoming UART byte; push strobe.
REQ-010 rx_full  output  1  RX FIFO full; rx_valid while full drops the byte.
REQ-011 tx_valid / tx_data  output  1 / 8  head of the TX FIFO.
REQ-012 tx_ready  input  1  consumer accepts; pop when tx_valid && tx_ready.
REQ-013 prog_stop  output  1  sticky flag, set by the stop write.
REQ-014 tx_ovf  output  1  sticky flag, a TX byte was dropped.

Function
REQ-015 Decode: mem_a[17:16]==2'b11 selects IO; otherwise RAM at index mem_a[RAM_ADDR_W-1:0].
REQ-016 RAM write: completes at the edge it is presented, zero wait.
REQ-017 Read latency: mem_din is valid exactly one cycle after the address.
- Registered source select plus registered data.
- Read-after-write to the same address in consecutive cycles returns the new byte.
REQ-018 Read 0x30000: pops the RX FIFO and returns the popped byte; RX empty returns 0x00 with no pop.
REQ-019 Read 0x30004: latches the 32-bit cycle counter into cnt_snap and returns byte [7:0].
REQ-020 Reads 0x30005 / 0x30006 / 0x30007: return cnt_snap bytes [15:8] / [23:16] / [31:24]; these reads do not re-latch.
REQ-021 Cycle counter: 32-bit, +1 every cycle after reset, wraps 0xFFFFFFFF -> 0.
REQ-022 Write 0x30000 with a non-zero byte pushes it to TX; a 0x00 byte is ignored.
REQ-023 Write 0x30004, any data: pushes 0x00 to TX and sets prog_stop.
REQ-024 TX push while full: byte dropped, tx_ovf set.
- A simultaneous pop frees the slot first, so the push is accepted.
REQ-025 RX push and pop in the same cycle: both occur; when empty, the popped byte is 0x00 and the pushed byte is stored.
REQ-026 Other IO addresses: writes ignored, reads return 0x00.
REQ-027 FIFO pointers are RAM_ADDR-independent, log2(FIFO_DEPTH)+1 bits wide.
- Wrap-around is by the MSB compare.

Reset
REQ-028 Reset assertion, asynchronous, clears:
- mem_din=0, tx_valid=0, tx_data=0, rx_full=0, prog_stop=0, tx_ovf=0;
- counter=0, cnt_snap=0, FIFO pointers=0.
REQ-029 RAM contents are not reset.
REQ-030 A transfer in flight at reset is discarded; the first read after deassertion follows REQ-017.

Configuration
REQ-031 Macro MEM_IO_RESP_TX_FIFO_EN defined: TX is a FIFO_DEPTH-entry FIFO.
REQ-032 MEM_IO_RESP_TX_FIFO_EN undefined: TX is a single holding register (depth 1); full whenever tx_valid; all other rules unchanged.

Structure
REQ-033 defines.v holds `IoBase (0x30000), `IoClk (0x30004) and the 2-bit IO-select compare value.
REQ-034 One sub-module io_byte_fifo (parameter DEPTH), instantiated for RX and TX.
REQ-035 RAM is an inferred reg array inside mem_io_resp.

Verification
REQ-036 Write 0xA5 to 0x00010, read 0x00010 next cycle -> mem_din=0xA5 one cycle after the read address.
REQ-037 rx pushes 0x41, 0x42; three reads of 0x30000 -> 0x41, 0x42, 0x00.
REQ-038 Read 0x30004..0x30007 on consecutive cycles at counter=0x00000123 -> 0x23, 0x01, 0x00, 0x00 (snapshot, no tear).
REQ-039 tx_ready=0; 9 non-zero writes to 0x30000 with depth 8 -> 8 bytes held, tx_ovf=1; a 0x00 write leaves the count unchanged.
REQ-040 Write 0x30004 -> prog_stop=1 and 0x00 emitted on TX; rst_n_in low mid-read -> all outputs 0 immediately.
